// File: rtl/dram_pkg.sv
// Shared types and default constants for the multi-lane DRAM behavioural model.
package dram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StReply
  } dram_state_e;

  localparam int unsigned LANES_DEF   = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF   = 64;
  localparam int unsigned ADDR_W_DEF  = 64;
  localparam int unsigned LATENCY_DEF = 20;

endpackage

// File: rtl/dram_lat_ctrl.sv
// Latency sequencer: accepts one request from IDLE, waits LATENCY cycles, then pulses reply.
module dram_lat_ctrl
  import dram_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  output logic capture,
  output logic reply
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(LATENCY - 1);

  dram_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             reply_q;

  assign req_ready = ready_q;
  assign reply     = reply_q;
  assign capture   = req_valid && ready_q;

  // The REPLY cycle starts LATENCY-1 WAIT cycles after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      reply_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= StReply;
              reply_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        StWait: begin
          if (cnt_q == CntLast) begin
            state_q <= StReply;
            reply_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReply: begin
          state_q <= StIdle;
          reply_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          ready_q <= 1'b1;
          reply_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dram_lane_model.sv
// Multi-lane DRAM model with fixed access latency. Define DRAM_OOB_ERR_EN to flag and
// suppress out-of-range lane addresses; otherwise upper address bits are ignored.
module dram_lane_model
  import dram_pkg::*;
#(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_rdwr,
  input  logic [LANES-1:0]               req_en,
  input  logic [LANES-1:0][ADDR_W-1:0]   req_addr,
  input  logic [LANES-1:0][DATA_W-1:0]   req_wdata,
  output logic [LANES-1:0]               rsp_valid,
  output logic [LANES-1:0][DATA_W-1:0]   rsp_rdata,
  output logic                           rsp_done,
  output logic [LANES-1:0]               rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic                           capture;
  logic                           reply;
  logic                           rdwr_q;
  logic [LANES-1:0]               en_q;
  logic [LANES-1:0][IDX_W-1:0]    idx_q;
  logic [LANES-1:0][DATA_W-1:0]   wdata_q;
  logic [LANES-1:0]               lane_ok;
  logic [DATA_W-1:0]              mem [DEPTH];

  dram_lat_ctrl #(
    .LATENCY(LATENCY)
  ) u_lat_ctrl (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .capture  (capture),
    .reply    (reply)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rdwr_q  <= 1'b1;
      en_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      rdwr_q  <= req_rdwr;
      en_q    <= req_en;
      wdata_q <= req_wdata;
      for (int i = 0; i < LANES; i++) begin
        idx_q[i] <= req_addr[i][IDX_W-1:0];
      end
    end
  end

`ifdef DRAM_OOB_ERR_EN
  logic [LANES-1:0] oob_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      oob_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < LANES; i++) begin
        oob_q[i] <= (req_addr[i] >= ADDR_W'(DEPTH));
      end
    end
  end

  assign lane_ok = ~oob_q;
  assign rsp_err = reply ? (en_q & oob_q) : '0;
`else
  logic unused_addr;
  assign unused_addr = ^req_addr;
  assign lane_ok     = '1;
  assign rsp_err     = '0;
`endif

  // Ascending lane order makes the highest-index lane win on duplicate write addresses.
  always_ff @(posedge clk) begin
    if (!reset && reply && !rdwr_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (en_q[i] && lane_ok[i]) begin
          mem[idx_q[i]] <= wdata_q[i];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_done  = reply;
    if (reply && rdwr_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (en_q[i]) begin
          rsp_valid[i] = 1'b1;
          if (lane_ok[i]) begin
            rsp_rdata[i] = mem[idx_q[i]];
          end
        end
      end
    end
  end

endmodule
